// File: rtl/sprite_plotter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_plotter: walks a W x H box from a latched origin, emitting one |
// | clipped pixel write per clock to a VGA adapter.                       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sprite_plotter #(
  parameter int         W         = 4,
  parameter int         H         = 4,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int         X_MAX     = 159,
  parameter int         Y_MAX     = 119
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       erase,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int CXW = (W > 1) ? $clog2(W) : 1;
  localparam int CYW = (H > 1) ? $clog2(H) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     r_state;
  logic [1:0]     w_state_nxt;
  logic [7:0]     r_x0;
  logic [6:0]     r_y0;
  logic [2:0]     r_col;
  logic [CXW-1:0] r_cx;
  logic [CYW-1:0] r_cy;

  logic [7:0]     w_x0_n;
  logic [6:0]     w_y0_n;
  logic [2:0]     w_col_n;
  logic [CXW-1:0] w_cx_n;
  logic [CYW-1:0] w_cy_n;
  logic [7:0]     w_x_n;
  logic [6:0]     w_y_n;
  logic [2:0]     w_colour_n;
  logic           w_plot_n;
  logic           w_busy_n;
  logic           w_done_n;
  logic           w_emit;
  logic [8:0]     w_sx;
  logic [7:0]     w_sy;
  logic           w_last;

  assign w_last = (r_cx == CXW'(W - 1)) && (r_cy == CYW'(H - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_DRAW;
      S_DRAW:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so this block computes the values presented
  // during the cycle after the coming edge: the pixel at the next counter.
  always_comb begin
    w_x0_n     = r_x0;
    w_y0_n     = r_y0;
    w_col_n    = r_col;
    w_cx_n     = r_cx;
    w_cy_n     = r_cy;
    w_x_n      = x_out;
    w_y_n      = y_out;
    w_colour_n = colour_out;
    w_plot_n   = 1'b0;
    w_busy_n   = 1'b0;
    w_done_n   = 1'b0;
    w_emit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_x0_n   = x_in;
          w_y0_n   = y_in;
          w_col_n  = erase ? BG_COLOUR : colour_in;
          w_cx_n   = '0;
          w_cy_n   = '0;
          w_busy_n = 1'b1;
          w_emit   = 1'b1;
        end
      end
      S_DRAW: begin
        w_busy_n = 1'b1;
        if (w_last) begin
          w_cx_n   = '0;
          w_cy_n   = '0;
          w_done_n = 1'b1;
        end else begin
          w_emit = 1'b1;
          if (r_cx == CXW'(W - 1)) begin
            w_cx_n = '0;
            w_cy_n = r_cy + 1'b1;
          end else begin
            w_cx_n = r_cx + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // Sums are one bit wider than the screen coordinate so off-screen
    // pixels clip instead of wrapping to the left/top edge.
    w_sx = {1'b0, w_x0_n} + 9'(w_cx_n);
    w_sy = {1'b0, w_y0_n} + 8'(w_cy_n);
    if (w_emit) begin
      w_x_n      = w_sx[7:0];
      w_y_n      = w_sy[6:0];
      w_colour_n = w_col_n;
      w_plot_n   = (w_sx <= 9'(X_MAX)) && (w_sy <= 8'(Y_MAX));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_x0       <= '0;
      r_y0       <= '0;
      r_col      <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_x0       <= w_x0_n;
      r_y0       <= w_y0_n;
      r_col      <= w_col_n;
      r_cx       <= w_cx_n;
      r_cy       <= w_cy_n;
      x_out      <= w_x_n;
      y_out      <= w_y_n;
      colour_out <= w_colour_n;
      plot       <= w_plot_n;
      busy       <= w_busy_n;
      done       <= w_done_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_plotter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sprite_plotter: directed scoreboard bench for sprite_plotter.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_sprite_plotter;

  logic       clock;
  logic       resetn;
  logic       start;
  logic       erase;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       done;

  int          n_total;
  int          n_pass;
  int          plot_cnt;
  logic [17:0] sb[$];

  sprite_plotter dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .erase      (erase),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Every plotted pixel must be the next one the scoreboard expects.
  always @(negedge clock) begin
    if (resetn && plot) begin
      plot_cnt++;
      check("plot_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("pixel", {14'd0, x_out, y_out, colour_out}, {14'd0, sb.pop_front()});
    end
  end

  // Called at a negedge; start is accepted at the next posedge. Cycle c is
  // the c-th negedge after that edge.
  task automatic run_sprite(input logic [7:0] x, input logic [6:0] y, input logic [2:0] col,
                            input logic er, input int inject, input logic [7:0] inj_x);
    int exp_plots;
    int plots_before;
    exp_plots = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int xs;
        int ys;
        xs = int'(x) + c;
        ys = int'(y) + r;
        if (xs <= 159 && ys <= 119) begin
          sb.push_back({xs[7:0], ys[6:0], er ? 3'b000 : col});
          exp_plots++;
        end
      end
    end
    plots_before = plot_cnt;
    start = 1'b1; x_in = x; y_in = y; colour_in = col; erase = er;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clock);
      if (c == 1 || c == inject + 1) start = 1'b0;
      if (c <= 17) begin
        check("busy_active", 32'(busy), 32'd1);
        check("done_timing", 32'(done), 32'(c == 17));
      end else begin
        check("busy_after", 32'(busy), 32'd0);
        check("done_after", 32'(done), 32'd0);
      end
      if (c == inject) begin
        start = 1'b1; x_in = inj_x; y_in = 7'd5; colour_in = 3'b001; erase = 1'b0;
      end
    end
    check("plot_count", 32'(plot_cnt - plots_before), 32'(exp_plots));
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    n_total = 0; n_pass = 0; plot_cnt = 0;
    resetn = 1'b0; start = 1'b0; erase = 1'b0;
    x_in = '0; y_in = '0; colour_in = '0;
    #1;
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_xyc", {14'd0, x_out, y_out, colour_out}, 32'd0);
    @(negedge clock); resetn = 1'b1;
    @(negedge clock);

    run_sprite(8'd10, 7'd20, 3'b100, 1'b0, -1, 8'd0);   // basic draw
    run_sprite(8'd10, 7'd20, 3'b111, 1'b1, -1, 8'd0);   // erase
    run_sprite(8'd158, 7'd118, 3'b010, 1'b0, -1, 8'd0); // corner clip
    run_sprite(8'd255, 7'd20, 3'b011, 1'b0, -1, 8'd0);  // fully clipped, no wrap
    run_sprite(8'd10, 7'd20, 3'b101, 1'b0, 5, 8'd50);   // start mid-draw ignored
    run_sprite(8'd30, 7'd40, 3'b110, 1'b0, 17, 8'd60);  // start in DONE ignored
    run_sprite(8'd70, 7'd80, 3'b001, 1'b0, -1, 8'd0);   // accepted normally after

    // Asynchronous reset mid-sprite
    sb.push_back({8'd20, 7'd30, 3'b111}); sb.push_back({8'd21, 7'd30, 3'b111});
    sb.push_back({8'd22, 7'd30, 3'b111}); sb.push_back({8'd23, 7'd30, 3'b111});
    sb.push_back({8'd20, 7'd31, 3'b111}); sb.push_back({8'd21, 7'd31, 3'b111});
    sb.push_back({8'd22, 7'd31, 3'b111});
    start = 1'b1; x_in = 8'd20; y_in = 7'd30; colour_in = 3'b111; erase = 1'b0;
    @(negedge clock); start = 1'b0;
    repeat (6) @(negedge clock);
    check("pre_rst_plot", 32'(plot), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("arst_plot", 32'(plot), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_xyc", {14'd0, x_out, y_out, colour_out}, 32'd0);
    check("arst_sb", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clock); resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("post_rst_idle", {29'd0, plot, busy, done}, 32'd0);
    end

    // Back-to-back: erase then redraw one column left
    run_sprite(8'd10, 7'd20, 3'b100, 1'b1, -1, 8'd0);
    run_sprite(8'd9, 7'd20, 3'b100, 1'b0, -1, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
